ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 14, word-address width of RAM port.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter STARVE_LIMIT, 4, consecutive CPU grants before forced loader grant; legal 1..15; used only with guard compiled in.
REQ-004 clock_50MHz  in  1  clock; all logic on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req  in  1  CPU access request; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_gnt.
REQ-007 cpu_we  in  1  CPU write (1) / read (0).
REQ-008 cpu_addr  in  ADDR_W  CPU word address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_gnt  out  1  one-cycle pulse, CPU access issued to RAM this cycle.
REQ-011 cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid.
REQ-012 ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader port, same rules as CPU port.
REQ-013 ldr_gnt, ldr_rvalid  out  1/1  loader equivalents of cpu_gnt/cpu_rvalid.
REQ-014 rdata  out  DATA_W  shared read data, equal to ram_rdata; qualified by cpu_rvalid or ldr_rvalid.
REQ-015 ram_addr, ram_we, ram_wdata  out  ADDR_W/1/DATA_W  registered RAM command.
REQ-016 ram_rdata  in  DATA_W  RAM read data, one-cycle synchronous latency.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RDATA.
REQ-018 IDLE: no request -> stay IDLE, ram_we=0.
REQ-019 IDLE with any request: winner's addr/we/wdata registered onto ram_*, winner's gnt set, -> ACCESS next cycle.
REQ-020 ACCESS: exactly one gnt high for this single cycle; RAM samples command at end of cycle; write -> IDLE; read -> RDATA.
REQ-021 RDATA: winner's rvalid high one cycle, rdata=ram_rdata, -> IDLE.
REQ-022 Latency: write, req sampled cycle 0 -> gnt cycle 1; read, gnt cycle 1 -> rvalid cycle 2; next arbitration in IDLE cycle 2 (write) or 3 (read).
REQ-023 ram_we SHALL be 1 only in ACCESS for a write; 0 in all other states.
REQ-024 Simultaneous cpu_req and ldr_req in IDLE: CPU wins unless starvation guard forces loader (REQ-031).
REQ-025 req held high after gnt is a new request; back-to-back accesses permitted, no gnt while not IDLE->ACCESS.
REQ-026 Requests arriving in ACCESS/RDATA are not sampled until the next IDLE; loser keeps req asserted.
REQ-027 cpu_gnt and ldr_gnt SHALL never be high together; same for rvalid pair.

Reset
REQ-028 Reset SHALL force state IDLE, all gnt/rvalid 0, ram_we 0, ram_addr 0, ram_wdata 0, starvation counter 0, on the next edge, including mid-ACCESS or mid-RDATA.
REQ-029 Transaction interrupted by Reset SHALL produce no rvalid; requester must re-request.

Configuration
REQ-030 Macro ARB_STARVE_GUARD_EN SHALL enable the starvation guard.
REQ-031 Defined: 4-bit counter increments on each CPU grant while ldr_req=1; when counter equals STARVE_LIMIT at an IDLE arbitration with ldr_req=1, loader wins; counter clears on loader grant or any cycle ldr_req=0.
REQ-032 Undefined: pure fixed CPU priority, no counter logic, STARVE_LIMIT ignored.

Verification
REQ-033 Loader write addr 0x0010 data 0xDEADBEEF, then loader read 0x0010 -> ldr_gnt cycle 1, ram_we=1 in cycle 1 only; read returns ldr_rvalid with rdata 0xDEADBEEF.
REQ-034 cpu_req and ldr_req rise same cycle (both reads) -> cpu_gnt first, ldr_gnt 3 cycles later, no overlap.
REQ-035 Guard defined, STARVE_LIMIT=4, cpu_req and ldr_req held high continuously -> grant sequence C,C,C,C,L repeating.
REQ-036 Guard undefined, same stimulus -> ldr_gnt never asserted while cpu_req high.
REQ-037 Reset asserted in ACCESS of a CPU write to 0x3FFF -> next cycle ram_we=0, state IDLE, no cpu_rvalid; RAM word 0x3FFF written at most once.
REQ-038 CPU reads 0x0000 back-to-back 5 times, req held -> gnt every 3 cycles, 5 rvalid pulses.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Request/grant port bundle for one requester of ram_port_arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
`timescale 1ns/1ps

interface ram_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;

    modport master (output req, we, addr, wdata, input gnt, rvalid);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port (CPU, loader) arbiter onto a single synchronous RAM port, fixed CPU priority.
// Define ARB_STARVE_GUARD_EN to force a loader grant after STARVE_LIMIT consecutive CPU grants.
`timescale 1ns/1ps

module ram_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock_50MHz,
    input  logic              Reset,
    ram_port_arbiter_if.slave cpu,
    ram_port_arbiter_if.slave ldr,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    state_t            state, state_next;
    logic              cpu_gnt_q, cpu_gnt_next;
    logic              ldr_gnt_q, ldr_gnt_next;
    logic              cpu_rvalid_q, cpu_rvalid_next;
    logic              ldr_rvalid_q, ldr_rvalid_next;
    logic              ram_we_next;
    logic [ADDR_W-1:0] ram_addr_next;
    logic [DATA_W-1:0] ram_wdata_next;
    logic              owner_ldr, owner_ldr_next;
    logic              force_ldr;
    logic              pick_ldr;

    assign pick_ldr = ldr.req && (!cpu.req || force_ldr);

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt, starve_cnt_next;

    assign force_ldr = (starve_cnt == 4'(STARVE_LIMIT));

    // Counts CPU wins while the loader is waiting; any loader-idle cycle restarts the count.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (!ldr.req) begin
            starve_cnt_next = 4'd0;
        end else if (state == IDLE) begin
            if (pick_ldr) begin
                starve_cnt_next = 4'd0;
            end else if (cpu.req) begin
                starve_cnt_next = starve_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clock_50MHz) begin
        if (Reset) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_cnt_next;
        end
    end
`else
    assign force_ldr = 1'b0;
`endif

    always_ff @(posedge clock_50MHz) begin
        if (Reset) begin
            state        <= IDLE;
            cpu_gnt_q    <= 1'b0;
            ldr_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            owner_ldr    <= 1'b0;
        end else begin
            state        <= state_next;
            cpu_gnt_q    <= cpu_gnt_next;
            ldr_gnt_q    <= ldr_gnt_next;
            cpu_rvalid_q <= cpu_rvalid_next;
            ldr_rvalid_q <= ldr_rvalid_next;
            ram_we       <= ram_we_next;
            ram_addr     <= ram_addr_next;
            ram_wdata    <= ram_wdata_next;
            owner_ldr    <= owner_ldr_next;
        end
    end

    // Grants, rvalids and ram_we are single-cycle strobes: they default low and are raised
    // only on the transition into the state where they belong.
    always_comb begin
        state_next      = state;
        cpu_gnt_next    = 1'b0;
        ldr_gnt_next    = 1'b0;
        cpu_rvalid_next = 1'b0;
        ldr_rvalid_next = 1'b0;
        ram_we_next     = 1'b0;
        ram_addr_next   = ram_addr;
        ram_wdata_next  = ram_wdata;
        owner_ldr_next  = owner_ldr;
        case (state)
            IDLE: begin
                if (cpu.req || ldr.req) begin
                    owner_ldr_next = pick_ldr;
                    ram_addr_next  = pick_ldr ? ldr.addr  : cpu.addr;
                    ram_wdata_next = pick_ldr ? ldr.wdata : cpu.wdata;
                    ram_we_next    = pick_ldr ? ldr.we    : cpu.we;
                    cpu_gnt_next   = !pick_ldr;
                    ldr_gnt_next   = pick_ldr;
                    state_next     = ACCESS;
                end
            end
            ACCESS: begin
                if (ram_we) begin
                    state_next = IDLE;
                end else begin
                    cpu_rvalid_next = !owner_ldr;
                    ldr_rvalid_next = owner_ldr;
                    state_next      = RDATA;
                end
            end
            RDATA: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cpu.gnt    = cpu_gnt_q;
    assign ldr.gnt    = ldr_gnt_q;
    assign cpu.rvalid = cpu_rvalid_q;
    assign ldr.rvalid = ldr_rvalid_q;
    assign rdata      = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed vector table, corner sequences, and a randomized
// run checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps

module tb_ram_port_arbiter;

    localparam int ADDR_W       = 14;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic              is_ldr;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    logic              clock_50MHz = 1'b0;
    logic              Reset       = 1'b1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_bus ();
    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ldr_bus ();

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock_50MHz (clock_50MHz),
        .Reset       (Reset),
        .cpu         (cpu_bus),
        .ldr         (ldr_bus),
        .rdata       (rdata),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #10 clock_50MHz = ~clock_50MHz;

    // Synchronous RAM with one-cycle read latency; also counts writes landing on the top word.
    logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
    int writes_3fff = 0;
    initial for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = '0;
    always @(posedge clock_50MHz) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            if (ram_addr == 14'h3FFF) writes_3fff <= writes_3fff + 1;
        end
        ram_rdata <= ram_mem[ram_addr];
    end

    initial begin
        #5ms;
        $display("[TB] FAIL timeout: simulation did not finish (actual=running required=finished)");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock_50MHz);
        @(negedge clock_50MHz);
    endtask

    task automatic setPort(input logic is_ldr, input logic req, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (is_ldr) begin
            ldr_bus.req = req; ldr_bus.we = we; ldr_bus.addr = addr; ldr_bus.wdata = wdata;
        end else begin
            cpu_bus.req = req; cpu_bus.we = we; cpu_bus.addr = addr; cpu_bus.wdata = wdata;
        end
    endtask

    task automatic driveIdle();
        setPort(1'b0, 1'b0, 1'b0, '0, '0);
        setPort(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic resetDut();
        driveIdle();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // One isolated transaction from IDLE: grant in cycle 1, rvalid (reads) in cycle 2.
    task automatic applyStimulus(input int idx, input vec_t v);
        setPort(v.is_ldr, 1'b1, v.we, v.addr, v.wdata);
        tick();
        checkOutput($sformatf("vec%0d_cpu_gnt", idx), 64'(cpu_bus.gnt), 64'(!v.is_ldr));
        checkOutput($sformatf("vec%0d_ldr_gnt", idx), 64'(ldr_bus.gnt), 64'(v.is_ldr));
        checkOutput($sformatf("vec%0d_ram_we", idx), 64'(ram_we), 64'(v.we));
        checkOutput($sformatf("vec%0d_ram_addr", idx), 64'(ram_addr), 64'(v.addr));
        if (v.we) checkOutput($sformatf("vec%0d_ram_wdata", idx), 64'(ram_wdata), 64'(v.wdata));
        setPort(v.is_ldr, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput($sformatf("vec%0d_ram_we_after", idx), 64'(ram_we), 64'(0));
        checkOutput($sformatf("vec%0d_gnt_after", idx), 64'({cpu_bus.gnt, ldr_bus.gnt}), 64'(0));
        checkOutput($sformatf("vec%0d_cpu_rvalid", idx), 64'(cpu_bus.rvalid), 64'(!v.is_ldr && !v.we));
        checkOutput($sformatf("vec%0d_ldr_rvalid", idx), 64'(ldr_bus.rvalid), 64'(v.is_ldr && !v.we));
        if (!v.we) checkOutput($sformatf("vec%0d_rdata", idx), 64'(rdata), 64'(v.exp_rdata));
        tick();
    endtask

    function automatic logic [ADDR_W-1:0] randAddr();
        logic [ADDR_W-1:0] base;
        base = ($urandom_range(0, 1) == 1) ? 14'h2A00 : 14'h0100;
        return base + 14'($urandom_range(0, 15));
    endfunction

    initial begin
        vec_t vecs[8];
        int c_first, l_first, both_g, both_rv, c_rv, l_rv, gcount, rvcount, l_grants, base_w;
        int gcyc[5];

        vecs[0] = '{1'b1, 1'b1, 14'h0010, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 14'h0010, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 14'h3FFE, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 14'h3FFE, 32'h0,        32'h12345678};
        vecs[4] = '{1'b0, 1'b0, 14'h0000, 32'h0,        32'h0};
        vecs[5] = '{1'b1, 1'b1, 14'h3FFF, 32'hA5A5A5A5, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 14'h3FFF, 32'h0,        32'hA5A5A5A5};
        vecs[7] = '{1'b1, 1'b0, 14'h3FFE, 32'h0,        32'h12345678};

        @(negedge clock_50MHz);
        resetDut();
        checkOutput("reset_gnt", 64'({cpu_bus.gnt, ldr_bus.gnt}), 64'(0));
        checkOutput("reset_rvalid", 64'({cpu_bus.rvalid, ldr_bus.rvalid}), 64'(0));
        checkOutput("reset_ram_we", 64'(ram_we), 64'(0));
        checkOutput("reset_ram_addr", 64'(ram_addr), 64'(0));
        checkOutput("reset_ram_wdata", 64'(ram_wdata), 64'(0));

        for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

        // Simultaneous reads: CPU first, loader three cycles later, never overlapping.
        setPort(1'b0, 1'b1, 1'b0, 14'h0010, '0);
        setPort(1'b1, 1'b1, 1'b0, 14'h3FFE, '0);
        c_first = -1; l_first = -1; both_g = 0; both_rv = 0; c_rv = 0; l_rv = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (cpu_bus.gnt && ldr_bus.gnt) both_g++;
            if (cpu_bus.rvalid && ldr_bus.rvalid) both_rv++;
            if (cpu_bus.gnt && c_first < 0) begin c_first = cyc; cpu_bus.req = 1'b0; end
            if (ldr_bus.gnt && l_first < 0) begin l_first = cyc; ldr_bus.req = 1'b0; end
            if (cpu_bus.rvalid) begin c_rv++; checkOutput("arb_cpu_rdata", 64'(rdata), 64'(32'hDEADBEEF)); end
            if (ldr_bus.rvalid) begin l_rv++; checkOutput("arb_ldr_rdata", 64'(rdata), 64'(32'h12345678)); end
        end
        checkOutput("arb_cpu_gnt_cycle", 64'(c_first), 64'(1));
        checkOutput("arb_ldr_gnt_cycle", 64'(l_first), 64'(4));
        checkOutput("arb_gnt_overlap", 64'(both_g), 64'(0));
        checkOutput("arb_rvalid_overlap", 64'(both_rv), 64'(0));
        checkOutput("arb_cpu_rvalid_count", 64'(c_rv), 64'(1));
        checkOutput("arb_ldr_rvalid_count", 64'(l_rv), 64'(1));

        // Five back-to-back CPU reads with req held: grant every third cycle.
        setPort(1'b0, 1'b1, 1'b0, 14'h0000, '0);
        gcount = 0; rvcount = 0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            tick();
            if (cpu_bus.gnt) begin
                if (gcount < 5) gcyc[gcount] = cyc;
                gcount++;
                if (gcount == 5) cpu_bus.req = 1'b0;
            end
            if (cpu_bus.rvalid) rvcount++;
        end
        checkOutput("b2b_gnt_count", 64'(gcount), 64'(5));
        checkOutput("b2b_rvalid_count", 64'(rvcount), 64'(5));
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("b2b_gnt%0d_cycle", i), 64'(gcyc[i]), 64'(1 + 3 * i));

        // Both requesters held high continuously.
        resetDut();
        setPort(1'b0, 1'b1, 1'b0, 14'h0000, '0);
        setPort(1'b1, 1'b1, 1'b0, 14'h0000, '0);
        gcount = 0; l_grants = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            if (cpu_bus.gnt || ldr_bus.gnt) begin
`ifdef ARB_STARVE_GUARD_EN
                checkOutput($sformatf("starve_grant%0d_ldr", gcount), 64'(ldr_bus.gnt),
                            64'((gcount % (STARVE_LIMIT + 1)) == STARVE_LIMIT));
`endif
                gcount++;
                if (ldr_bus.gnt) l_grants++;
            end
        end
        checkOutput("starve_grant_count", 64'(gcount), 64'(10));
`ifdef ARB_STARVE_GUARD_EN
        checkOutput("starve_ldr_grants", 64'(l_grants), 64'(10 / (STARVE_LIMIT + 1)));
`else
        checkOutput("starve_ldr_grants", 64'(l_grants), 64'(0));
`endif
        driveIdle();
        for (int i = 0; i < 3; i++) tick();

        // Reset during ACCESS of a CPU write to the top word.
        base_w = writes_3fff;
        setPort(1'b0, 1'b1, 1'b1, 14'h3FFF, 32'hCAFEF00D);
        tick();
        checkOutput("rstw_cpu_gnt", 64'(cpu_bus.gnt), 64'(1));
        checkOutput("rstw_ram_we", 64'(ram_we), 64'(1));
        Reset = 1'b1;
        driveIdle();
        tick();
        Reset = 1'b0;
        checkOutput("rstw_ram_we_after", 64'(ram_we), 64'(0));
        checkOutput("rstw_ram_addr_after", 64'(ram_addr), 64'(0));
        checkOutput("rstw_ram_wdata_after", 64'(ram_wdata), 64'(0));
        checkOutput("rstw_gnt_after", 64'({cpu_bus.gnt, ldr_bus.gnt}), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rstw_no_rvalid", 64'({cpu_bus.rvalid, ldr_bus.rvalid}), 64'(0));
        end
        checkOutput("rstw_write_at_most_once", 64'((writes_3fff - base_w) <= 1), 64'(1));

        // Reset during ACCESS of a read: the pending rvalid must be dropped.
        setPort(1'b0, 1'b1, 1'b0, 14'h0010, '0);
        tick();
        checkOutput("rstr_cpu_gnt", 64'(cpu_bus.gnt), 64'(1));
        Reset = 1'b1;
        driveIdle();
        tick();
        Reset = 1'b0;
        checkOutput("rstr_no_rvalid0", 64'({cpu_bus.rvalid, ldr_bus.rvalid}), 64'(0));
        tick();
        checkOutput("rstr_no_rvalid1", 64'({cpu_bus.rvalid, ldr_bus.rvalid}), 64'(0));
        setPort(1'b1, 1'b1, 1'b1, 14'h0020, 32'h0BADF00D);
        tick();
        checkOutput("rstr_idle_regrant", 64'(ldr_bus.gnt), 64'(1));
        driveIdle();
        tick();
        tick();

        // Randomized traffic against a transaction-level model of the arbitration rules.
        begin
            logic [DATA_W-1:0] model_mem [int];
            int busy, streak;
            logic e_cg, e_lg, e_we, e_cr, e_lr, p_cr, p_lr;
            logic [ADDR_W-1:0] e_addr;
            logic [DATA_W-1:0] e_wd, e_rd, p_rd;
            logic c_pend, l_pend, c_we, l_we, lw, force_l;
            logic [ADDR_W-1:0] c_addr, l_addr, a;
            logic [DATA_W-1:0] c_wd, l_wd, d;

            resetDut();
            busy = 0; streak = 0;
            e_cg = 0; e_lg = 0; e_we = 0; e_cr = 0; e_lr = 0; p_cr = 0; p_lr = 0;
            e_addr = '0; e_wd = '0; e_rd = '0; p_rd = '0;
            c_pend = 0; l_pend = 0; c_we = 0; l_we = 0;
            c_addr = '0; l_addr = '0; c_wd = '0; l_wd = '0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                checkOutput("rnd_cpu_gnt", 64'(cpu_bus.gnt), 64'(e_cg));
                checkOutput("rnd_ldr_gnt", 64'(ldr_bus.gnt), 64'(e_lg));
                checkOutput("rnd_ram_we", 64'(ram_we), 64'(e_we));
                checkOutput("rnd_cpu_rvalid", 64'(cpu_bus.rvalid), 64'(e_cr));
                checkOutput("rnd_ldr_rvalid", 64'(ldr_bus.rvalid), 64'(e_lr));
                if (e_cg || e_lg) checkOutput("rnd_ram_addr", 64'(ram_addr), 64'(e_addr));
                if (e_we) checkOutput("rnd_ram_wdata", 64'(ram_wdata), 64'(e_wd));
                if (e_cr || e_lr) checkOutput("rnd_rdata", 64'(rdata), 64'(e_rd));

                if (cpu_bus.gnt) c_pend = 0;
                if (ldr_bus.gnt) l_pend = 0;
                if (!c_pend && $urandom_range(0, 2) != 0) begin
                    c_pend = 1; c_we = 1'($urandom_range(0, 1)); c_addr = randAddr(); c_wd = $urandom;
                end
                if (!l_pend && $urandom_range(0, 1) != 0) begin
                    l_pend = 1; l_we = 1'($urandom_range(0, 1)); l_addr = randAddr(); l_wd = $urandom;
                end
                setPort(1'b0, c_pend, c_we, c_addr, c_wd);
                setPort(1'b1, l_pend, l_we, l_addr, l_wd);

                e_cr = p_cr; e_lr = p_lr; e_rd = p_rd;
                p_cr = 0; p_lr = 0; e_cg = 0; e_lg = 0; e_we = 0;
`ifdef ARB_STARVE_GUARD_EN
                force_l = (streak == STARVE_LIMIT);
`else
                force_l = 0;
`endif
                lw = 0;
                if (busy > 0) begin
                    busy--;
                    if (!l_pend) streak = 0;
                end else begin
                    lw = l_pend && (!c_pend || force_l);
                    if (c_pend || l_pend) begin
                        a = lw ? l_addr : c_addr;
                        d = lw ? l_wd : c_wd;
                        e_cg = !lw; e_lg = lw; e_we = lw ? l_we : c_we; e_addr = a; e_wd = d;
                        if (e_we) begin
                            model_mem[int'(a)] = d;
                            busy = 1;
                        end else begin
                            p_cr = !lw; p_lr = lw;
                            p_rd = model_mem.exists(int'(a)) ? model_mem[int'(a)] : '0;
                            busy = 2;
                        end
                    end
                    if (!l_pend || lw) streak = 0;
                    else if (c_pend) streak++;
                end
                tick();
            end
            driveIdle();
            for (int i = 0; i < 3; i++) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
